// File: rtl/clk_div_pkg.sv
// clk_div_pkg: state encoding, reset defaults and config legality check
// shared by the programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

    localparam int unsigned DEF_DIV   = 2;
    localparam int unsigned DEF_PHASE = 0;

    function automatic logic cfg_legal(logic [31:0] div, logic [31:0] phase);
        return div >= 32'd2 && phase < div;
    endfunction

endpackage

// File: rtl/clk_div_phase_gen.sv
// clk_div_phase_gen: divided, phase-offset clock from mclk; run-time reconfiguration
// takes effect only at a period boundary so bclk_out never glitches.
module clk_div_phase_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DEF_DIV   = clk_div_pkg::DEF_DIV,
    parameter int unsigned DEF_PHASE = clk_div_pkg::DEF_PHASE
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic             bclk_out,
    output logic             rise_stb,
    output logic             locked
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, dly_q, dly_d, div_q, div_d, ph_q, ph_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d, pph_q, pph_d;
    logic             arm_q, arm_d, pend_q, pend_d, bclk_q, bclk_d;
    logic             rise_q, rise_d, lock_q, lock_d, err_q, err_d;
    logic             acc, ok, idle, wrap, fire, stop, take_now;

    // arm_q: low-idle prefix before the first rise, dly_q counts its remaining cycles
    assign cfg_ready = !pend_q;
    assign acc       = cfg_valid && cfg_ready;
    assign ok        = cfg_legal(32'(cfg_div), 32'(cfg_phase));
    assign idle      = state_q == IDLE;
    assign wrap      = !idle && !arm_q && cnt_q == div_q - 1'b1;
    assign fire      = !idle && arm_q && dly_q == '0;
    assign stop      = state_q == STOPPING && !enable && wrap;
    assign take_now  = acc && ok && (idle || stop);

    always_comb begin
        state_d = idle ? (enable ? RUN : IDLE) : stop ? IDLE : enable ? RUN : STOPPING;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        arm_d   = arm_q;
        div_d   = div_q;
        ph_d    = ph_q;
        pend_d  = pend_q;
        pdiv_d  = pdiv_q;
        pph_d   = pph_q;
        lock_d  = lock_q;
        err_d   = acc && !ok;
        if (!idle) begin
            if (arm_q) begin
                dly_d = fire ? '0 : dly_q - 1'b1;
                arm_d = !fire;
                cnt_d = '0;
            end else begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
            end
        end
        if (wrap)
            lock_d = 1'b1;
        if (wrap && pend_q) begin
            div_d  = pdiv_q;
            ph_d   = pph_q;
            pend_d = 1'b0;
            lock_d = 1'b0;
            if (!stop && pph_q != '0) begin
                arm_d = 1'b1;
                dly_d = pph_q - 1'b1;
            end
        end
        if (take_now) begin
            div_d  = cfg_div;
            ph_d   = cfg_phase;
            lock_d = 1'b0;
        end else if (acc && ok) begin
            pend_d = 1'b1;
            pdiv_d = cfg_div;
            pph_d  = cfg_phase;
        end
        if (idle && enable) begin
            arm_d = 1'b1;
            dly_d = ph_d;
        end
        bclk_d = state_d != IDLE && !arm_d && cnt_d < (div_d >> 1);
        rise_d = bclk_d && !bclk_q;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            arm_q   <= 1'b0;
            div_q   <= CNT_W'(DEF_DIV);
            ph_q    <= CNT_W'(DEF_PHASE);
            pend_q  <= 1'b0;
            pdiv_q  <= '0;
            pph_q   <= '0;
            bclk_q  <= 1'b0;
            rise_q  <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            arm_q   <= arm_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            pend_q  <= pend_d;
            pdiv_q  <= pdiv_d;
            pph_q   <= pph_d;
            bclk_q  <= bclk_d;
            rise_q  <= rise_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    assign bclk_out = bclk_q;
    assign rise_stb = rise_q;
    assign locked   = lock_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_clk_div_phase_gen.sv
// tb_clk_div_phase_gen: directed spec scenarios plus random traffic, checked every cycle
// against a waveform-queue model of the generator.
module tb_clk_div_phase_gen;

    logic       mclk = 1'b0;
    logic       rst = 1'b1, enable = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0, cfg_phase = 8'd0;
    logic       cfg_ready, cfg_err, bclk_out, rise_stb, locked;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    clk_div_phase_gen dut (
        .mclk(mclk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .bclk_out(bclk_out), .rise_stb(rise_stb), .locked(locked)
    );

    always #5 mclk = !mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Model: the future bclk waveform is kept as a queue of levels; an empty queue is a
    // segment boundary, and m_segp says whether that segment was a full period.
    bit m_idle, m_stop, m_segp, m_bclk, m_rise, m_lock, m_err, m_pv;
    int m_n, m_p, m_pn, m_pp;
    bit wave[$];

    task automatic model_reset();
        m_idle = 1; m_stop = 0; m_segp = 0; m_bclk = 0; m_rise = 0; m_lock = 0;
        m_err = 0; m_pv = 0; m_n = 2; m_p = 0; m_pn = 0; m_pp = 0;
        wave.delete();
    endtask

    task automatic model_edge();
        bit acc, ok, old, went_idle;
        int d, p;
        if (rst) begin
            model_reset();
            return;
        end
        old = m_bclk;
        d = int'(cfg_div);
        p = int'(cfg_phase);
        acc = cfg_valid && !m_pv;
        ok = d >= 2 && p < d;
        m_err = acc && !ok;
        went_idle = 0;
        if (m_idle) begin
            if (acc && ok) begin m_n = d; m_p = p; m_lock = 0; end
            if (enable) begin
                m_idle = 0;
                m_segp = 0;
                wave.delete();
                repeat (m_p) wave.push_back(1'b0);
            end
            m_bclk = 0;
        end else begin
            if (wave.size() == 0) begin
                if (m_segp) m_lock = 1;
                if (m_segp && m_stop && !enable) begin
                    if (m_pv) begin m_n = m_pn; m_p = m_pp; m_pv = 0; m_lock = 0; end
                    if (acc && ok) begin m_n = d; m_p = p; m_lock = 0; end
                    m_idle = 1;
                    went_idle = 1;
                end else begin
                    if (m_segp && m_pv) begin
                        m_n = m_pn; m_p = m_pp; m_pv = 0; m_lock = 0;
                        repeat (m_p) wave.push_back(1'b0);
                    end
                    for (int i = 0; i < m_n; i++) wave.push_back(i < m_n / 2);
                    m_segp = 1;
                end
            end
            if (!went_idle && acc && ok) begin m_pv = 1; m_pn = d; m_pp = p; end
            m_bclk = m_idle ? 1'b0 : wave.pop_front();
        end
        m_stop = !m_idle && !enable;
        m_rise = m_bclk && !old;
    endtask

    task automatic tick();
        @(posedge mclk);
        model_edge();
        #1;
        cyc++;
        check("bclk_out", 32'(bclk_out), 32'(m_bclk));
        check("rise_stb", 32'(rise_stb), 32'(m_rise));
        check("locked", 32'(locked), 32'(m_lock));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
    endtask

    task automatic cfg(input int d, input int p);
        cfg_valid = 1'b1;
        cfg_div = 8'(d);
        cfg_phase = 8'(p);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic stop_idle();
        enable = 1'b0;
        repeat (24) tick();
        check("idle_low", 32'(bclk_out), 0);
    endtask

    task automatic measure(output int first, output int per, output int hi);
        int r1, r2;
        r1 = -1; r2 = -1; hi = 0;
        enable = 1'b1;
        tick();
        check("start_low", 32'(bclk_out), 0);
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (rise_stb) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            if (r1 >= 0 && r2 < 0 && bclk_out) hi++;
        end
        first = r1;
        per = r2 - r1;
    endtask

    initial begin
        int f, per, hi, k;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_bclk", 32'(bclk_out), 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_locked", 32'(locked), 0);
        // N=4 P=0 from idle
        cfg(4, 0);
        measure(f, per, hi);
        check("t1_first", f, 1);
        check("t1_period", per, 4);
        check("t1_high", hi, 2);
        check("t1_locked", 32'(locked), 1);
        // reconfigure to N=6 P=1 while running
        repeat (2) tick();
        cfg(6, 1);
        check("t3_ready", 32'(cfg_ready), 0);
        repeat (24) tick();
        check("t3_ready_after", 32'(cfg_ready), 1);
        // enable dropped then restored before the wrap, then a real stop
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        repeat (12) tick();
        stop_idle();
        // N=5 P=3 from idle
        cfg(5, 3);
        measure(f, per, hi);
        check("t2_first", f, 4);
        check("t2_period", per, 5);
        check("t2_high", hi, 2);
        // illegal configs while running
        cfg(1, 0);
        check("t4_err_n1", 32'(cfg_err), 1);
        check("t4_ready_n1", 32'(cfg_ready), 1);
        tick();
        cfg(4, 4);
        check("t4_err_p4", 32'(cfg_err), 1);
        check("t4_ready_p4", 32'(cfg_ready), 1);
        repeat (10) tick();
        // reset while high restores the default divide ratio
        k = 0;
        while (!bclk_out && k < 12) begin tick(); k++; end
        check("t6_high", 32'(bclk_out), 1);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        check("t6_bclk", 32'(bclk_out), 0);
        check("t6_locked", 32'(locked), 0);
        rst = 1'b0;
        tick();
        measure(f, per, hi);
        check("t6_def_period", per, 2);
        check("t6_def_high", hi, 1);
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 599) == 0;
            if ($urandom_range(0, 29) == 0) enable = !enable;
            cfg_valid = $urandom_range(0, 11) == 0;
            cfg_div = 8'($urandom_range(0, 9));
            cfg_phase = 8'($urandom_range(0, 9));
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
